// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC owner, ROM driver and IF/ID register with valid/ready handoff to decode.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_CHECK_EN.
module if_fetch_stage #(
  parameter int                     PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = 'h8000_0000,
  parameter int                     PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                rom_ce,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [31:0]         rom_inst,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [31:0]         id_inst,
  output logic                fetch_misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic                valid_q;
  logic                load;
  logic                take_redirect;

  assign rom_ce   = (state == S_RUN);
  assign rom_addr = {2'b00, pc[PC_WIDTH-1:2]};
  assign id_valid = valid_q & ~redirect_valid;
  assign load     = ~valid_q | id_ready;

  // HALT is terminal, so redirects arriving there are dropped.
  assign take_redirect = redirect_valid && (state != S_HALT);

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;
  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      valid_q <= 1'b0;
      id_pc   <= '0;
      id_inst <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else if (take_redirect) begin
      // Flush: the IF/ID payload is left stale but masked by valid_q=0.
      pc      <= redirect_pc;
      valid_q <= 1'b0;
      if (state == S_IDLE) begin
        state <= S_RUN;
      end
`ifdef IFU_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state      <= S_HALT;
        misalign_q <= 1'b1;
      end
`endif
    end else begin
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN: begin
          if (load) begin
            id_pc   <= pc;
            id_inst <= rom_inst;
            valid_q <= 1'b1;
            pc      <= pc + PC_WIDTH'(PC_STEP);
          end
        end
        S_HALT:  valid_q <= 1'b0;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
